// File: rtl/instr_decode_stage.sv
// Assembles 64-bit instructions from a narrow beat stream, decodes each one
// into operand fields, and queues the results in a small FIFO for the controller.
module instr_decode_stage #(
    parameter int BEAT_W   = 16,
    parameter int DEPTH    = 4,
    parameter int DROP_NOP = 0,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BEAT_W-1:0]          in_beat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_opcode,
    output logic [4:0]                 out_dest,
    output logic [9:0]                 out_length_or_cols,
    output logic [9:0]                 out_rows,
    output logic [23:0]                out_addr,
    output logic [4:0]                 out_b,
    output logic [4:0]                 out_x,
    output logic [4:0]                 out_w,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           illegal_count
);

    localparam int NB   = 64 / BEAT_W;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        illegal;
        logic [4:0]  w;
        logic [4:0]  x;
        logic [4:0]  b;
        logic [23:0] addr;
        logic [9:0]  rows;
        logic [9:0]  loc;
        logic [4:0]  dest;
        logic [4:0]  opcode;
    } dec_t;

    function automatic dec_t decode(input logic [63:0] word);
        dec_t d;
        d        = '0;
        d.opcode = word[4:0];
        case (word[4:0])
            5'h00: ;
            5'h01, 5'h03: begin
                d.dest = word[9:5];
                d.loc  = word[19:10];
                d.addr = word[63:40];
            end
            5'h02: begin
                d.dest = word[9:5];
                d.loc  = word[19:10];
                d.rows = word[29:20];
                d.addr = word[63:40];
            end
            5'h04: begin
                d.dest = word[9:5];
                d.loc  = word[19:10];
                d.rows = word[29:20];
                d.b    = word[34:30];
                d.x    = word[39:35];
                d.w    = word[44:40];
            end
            5'h05: begin
                d.dest = word[9:5];
                d.x    = word[14:10];
                d.loc  = word[29:20];
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [BC_W-1:0] beat_cnt;
    logic [63:0]     word_p0;
    logic [63:0]     word_c;
    dec_t            dec_c;
    dec_t            mem [DEPTH];
    dec_t            head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            last_beat, fifo_full, accept, push, pop, drop;

    assign last_beat = (beat_cnt == BC_W'(NB - 1));
    assign fifo_full = (occupancy == OW'(DEPTH));
    assign in_ready  = !(last_beat && fifo_full);
    assign out_valid = (occupancy != '0);
    assign accept    = in_valid && in_ready && !flush;

    // Completed word: stored lower beats with the final beat spliced in on top.
    always_comb begin
        word_c = word_p0;
        word_c[(NB-1)*BEAT_W +: BEAT_W] = in_beat;
        dec_c = decode(word_c);
    end

    assign drop = (DROP_NOP != 0) && (dec_c.opcode == 5'h00);
    assign push = accept && last_beat && !drop;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            illegal_count <= '0;
        end else if (flush) begin
            beat_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (accept)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                occupancy <= occupancy + 1'b1;
            else if (pop && !push)
                occupancy <= occupancy - 1'b1;
            if (push && dec_c.illegal)
                illegal_count <= sat_inc(illegal_count);
        end
    end

    // Data storage carries no reset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        if (accept && !last_beat)
            word_p0[int'(beat_cnt)*BEAT_W +: BEAT_W] <= in_beat;
        if (push)
            mem[wr_ptr] <= dec_c;
    end

    assign head               = out_valid ? mem[rd_ptr] : '0;
    assign out_opcode         = head.opcode;
    assign out_dest           = head.dest;
    assign out_length_or_cols = head.loc;
    assign out_rows           = head.rows;
    assign out_addr           = head.addr;
    assign out_b              = head.b;
    assign out_x              = head.x;
    assign out_w              = head.w;
    assign out_illegal        = head.illegal;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Sequential successor to the combinational instruction decoder. Assembles 64-bit instructions from a narrow instruction-memory beat stream with a valid/ready handshake, and decodes each into opcode and operand fields. Queues decoded instructions in a parametrised FIFO for the controller. Also flags illegal opcodes, optionally drops NOPs, and supports a synchronous flush.

Parameters:
BEAT_W, 16, input beat width in bits; must be one of 8/16/32/64, so that 64 % BEAT_W == 0
DEPTH, 4, decoded-instruction FIFO depth; >= 1
DROP_NOP, 0, when 1, opcode 5'h00 is never pushed into the FIFO
CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of the partial instruction and the FIFO
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
in_beat  input  BEAT_W  instruction beat, least-significant beat first
out_valid  output  1  FIFO head holds a decoded instruction
out_ready  input  1  consumer pops the head when out_valid && out_ready
out_opcode  output  5  head opcode
out_dest  output  5  head destination buffer
out_length_or_cols  output  10  head length/cols
out_rows  output  10  head rows
out_addr  output  24  head DRAM address
out_b  output  5  head bias buffer
out_x  output  5  head input buffer
out_w  output  5  head weight buffer
out_illegal  output  1  head opcode is not 5'h00..5'h05
occupancy  output  $clog2(DEPTH+1)  FIFO entries in use
illegal_count  output  CNT_W  count of illegal instructions pushed, saturating

Behaviour:
- Reset (async, rst=1):
  - beat counter, FIFO pointers, occupancy and illegal_count go to 0.
  - out_valid=0 and all out_* fields read 0.
  - in_ready=1 once rst deasserts.
- Beat assembly:
  - NB = 64/BEAT_W beats per instruction. Beat k (k = 0..NB-1) is written into bits [k*BEAT_W +: BEAT_W].
  - The beat counter wraps NB-1 -> 0 on acceptance of the last beat.
  - For BEAT_W=64, every beat is a full instruction.
- in_ready = !(beat_cnt == NB-1 && fifo_full). Non-final beats are always accepted.
  - A same-cycle pop does not free space for a push; this is deliberately conservative, with no comb path from out_ready to in_ready.
- Decode happens on the completed word (the last beat combined with the stored lower beats) in the cycle the last beat is accepted. All unused fields are 0.
  - 5'h00 NOP: no fields.
  - 5'h01 LOAD_V / 5'h03 STORE: dest=[9:5], length_or_cols=[19:10], addr=[63:40].
  - 5'h02 LOAD_M: as LOAD_V, plus rows=[29:20].
  - 5'h04 GEMV: dest=[9:5], cols=[19:10], rows=[29:20], b=[34:30], x=[39:35], w=[44:40].
  - 5'h05 RELU: dest=[9:5], x=[14:10], length_or_cols=[29:20].
  - Other opcodes: illegal=1, opcode retained, all other fields 0.
- Push:
  - Each completed word is written to the FIFO tail on the cycle its last beat is accepted.
  - Exception: when DROP_NOP=1 and opcode==0, the word is discarded and no push occurs.
  - An illegal push increments illegal_count, saturating at 2^CNT_W - 1.
- Latency: last beat accepted at cycle N -> out_valid=1 with its fields at cycle N+1 if the FIFO was empty.
- Output:
  - out_* are registered FIFO head contents; out_valid = (occupancy != 0).
  - Held stable while out_valid && !out_ready.
  - When the FIFO is empty, out_* read 0.
- Simultaneous push and pop with the FIFO non-empty: occupancy is unchanged and order is preserved.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- flush, which has priority over any push/pop in the same cycle:
  - Next cycle, beat_cnt=0, FIFO empty and out_valid=0.
  - The beat presented during flush is discarded even if in_valid=1.
  - illegal_count is not cleared.
- rst asserted mid-instruction or mid-drain: immediate clear as in Reset; the partial word is lost.

Test Plan:
- LOAD_M, BEAT_W=16: beats 0x4062, 0x0080, 0x0000, 0x0010 (word 0x0010000000804062) -> next cycle out_valid=1, opcode=2, dest=3, cols=16, rows=8, addr=0x001000, b=x=w=0, illegal=0.
- GEMV word 0x0000031101008024 -> opcode=4, dest=1, cols=32, rows=16, b=4, x=2, w=3, addr=0.
- RELU word 0x0000000004001445 -> opcode=5, dest=2, x=5, length_or_cols=64, rows=0; also repeated with BEAT_W=8 and 64 giving identical fields.
- Backpressure, DEPTH=4, out_ready=0: push 4 instructions -> occupancy=4, in_ready=0 only on the final beat of the 5th. Raise out_ready for 1 cycle -> head pops, the 5th is accepted next cycle, and FIFO order is preserved.
- Opcode 5'h1F pushed 300 times with CNT_W=8 -> out_illegal=1 with other fields 0, and illegal_count saturates at 255. With DROP_NOP=1, a NOP word yields no out_valid.
- Flush after 2 of 4 beats while the FIFO holds 2 entries -> next cycle occupancy=0 and out_valid=0. The following 4 beats decode as a clean new instruction. rst asserted mid-beat gives the same result asynchronously.
